// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder.
// master: request producer and FIFO consumer. slave: the encoder itself.
interface instr_encoder_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [31:0]     in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_err;
  logic [CntW-1:0] count;

  modport master (
    output flush, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, count
  );

  modport slave (
    input  flush, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs an op code plus register/immediate fields into a 32-bit RV64I word
// (16-op subset) and buffers the result in a DEPTH-entry FIFO.
// Optional feature: define CHECK_IMM_EN to store a per-entry immediate-range error flag;
// otherwise out_err is tied to 0 and no check logic exists.
module instr_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            reset_n,
  instr_encoder_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {FmtI, FmtR, FmtU, FmtS, FmtB, FmtJ} fmt_e;

  fmt_e            fmt;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm;
  logic [31:0]     enc_word;

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready;
  logic            out_valid;
  logic            push;
  logic            pop;

  assign imm = bus.in_imm;

  // Op code to format, major opcode and function fields.
  always_comb begin
    fmt    = FmtI;
    opcode = 7'b0010011;
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    unique case (bus.in_op)
      4'd0:  funct3 = 3'b000;                                       // ADDI
      4'd1:  funct3 = 3'b100;                                       // XORI
      4'd2:  funct3 = 3'b110;                                       // ORI
      4'd3:  funct3 = 3'b111;                                       // ANDI
      4'd4:  begin fmt = FmtU; opcode = 7'b0110111; end             // LUI
      4'd5:  begin fmt = FmtU; opcode = 7'b0010111; end             // AUIPC
      4'd6:  begin fmt = FmtR; opcode = 7'b0110011; end             // ADD
      4'd7:  begin
        fmt    = FmtR;                                              // SUB
        opcode = 7'b0110011;
        funct7 = 7'b0100000;
      end
      4'd8:  begin fmt = FmtR; opcode = 7'b0110011; funct3 = 3'b111; end  // AND
      4'd9:  begin fmt = FmtR; opcode = 7'b0110011; funct3 = 3'b110; end  // OR
      4'd10: begin fmt = FmtR; opcode = 7'b0110011; funct3 = 3'b100; end  // XOR
      4'd11: begin fmt = FmtS; opcode = 7'b0100011; funct3 = 3'b011; end  // SD
      4'd12: begin fmt = FmtI; opcode = 7'b0000011; funct3 = 3'b011; end  // LD
      4'd13: begin fmt = FmtJ; opcode = 7'b1101111; end                   // JAL
      4'd14: begin fmt = FmtI; opcode = 7'b1100111; end                   // JALR
      4'd15: begin fmt = FmtB; opcode = 7'b1100011; end                   // BEQ
    endcase
  end

  // Field packing; fields a format does not carry are simply not used.
  always_comb begin
    enc_word = '0;
    unique case (fmt)
      FmtI: enc_word = {imm[11:0], bus.in_rs1, funct3, bus.in_rd, opcode};
      FmtR: enc_word = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, opcode};
      FmtU: enc_word = {imm[31:12], bus.in_rd, opcode};
      FmtS: enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, funct3, imm[4:0], opcode};
      FmtB: enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, funct3, imm[4:1],
                        imm[11], opcode};
      FmtJ: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, opcode};
      default: enc_word = '0;
    endcase
  end

  // No bypass: a full FIFO refuses input even when it pops in the same cycle.
  assign in_ready  = reset_n & (count_q < CntW'(DEPTH)) & ~bus.flush;
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;

  // Pointer and occupancy next state; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO control state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO word storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

`ifdef CHECK_IMM_EN
  logic enc_err;
  logic err_q [DEPTH];

  // Range check on the full 32-bit immediate; sign bits above the field must all agree.
  always_comb begin
    enc_err = 1'b0;
    unique case (fmt)
      FmtI, FmtS: enc_err = (imm[31:11] != '0) && (imm[31:11] != '1);
      FmtB:       enc_err = ((imm[31:12] != '0) && (imm[31:12] != '1)) || imm[0];
      FmtJ:       enc_err = ((imm[31:20] != '0) && (imm[31:20] != '1)) || imm[0];
      FmtU:       enc_err = (imm[11:0] != '0);
      default:    enc_err = 1'b0;
    endcase
  end

  // Error flag storage, written alongside the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) err_q[i] <= 1'b0;
    end else if (push) begin
      err_q[wr_ptr_q] <= enc_err;
    end
  end

  assign bus.out_err = out_valid & err_q[rd_ptr_q];
`else
  assign bus.out_err = 1'b0;
`endif
endmodule
